// File: rtl/adder_rr_scheduler.sv
// Round-robin scheduler sharing one 32-bit add/sub unit among NREQ requesters.
// One op in flight; the result is held with valid/ready until the consumer takes it.
module adder_rr_scheduler #(
    parameter int unsigned NREQ = 4,
    localparam int unsigned IDW = (NREQ > 2) ? $clog2(NREQ) : 1
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ-1:0]      req_op,
    input  logic [32*NREQ-1:0]   req_a,
    input  logic [32*NREQ-1:0]   req_b,
    output logic [NREQ-1:0]      gnt,
    output logic [31:0]          add_in0,
    output logic [31:0]          add_in1,
    output logic                 add_op,
    input  logic [31:0]          add_sum,
    input  logic                 add_ovf,
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic [IDW-1:0]       res_id,
    output logic [31:0]          res_sum,
    output logic                 res_ovf
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t         state;
    state_t         state_nx;
    logic [IDW-1:0] ptr;
    logic [IDW-1:0] id;
    logic [IDW-1:0] win;
    logic           found;
    logic           can_grant;
    logic           do_grant;

    // Round-robin search starting just after the last winner.
    always_comb begin
        found = 1'b0;
        win   = '0;
        for (int k = 1; k <= int'(NREQ); k++) begin
            if (!found && req[(int'(ptr) + k) % int'(NREQ)]) begin
                found = 1'b1;
                win   = IDW'((int'(ptr) + k) % int'(NREQ));
            end
        end
    end

    // Grant is combinational so a waiting requester is served in the accept cycle.
    always_comb begin
        can_grant = reset_n && ((state == IDLE) || ((state == HOLD) && res_ready));
        do_grant  = can_grant && found;
        gnt       = do_grant ? (NREQ'(1) << win) : '0;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (do_grant) state_nx = EXEC;
            EXEC:    state_nx = HOLD;
            HOLD:    if (res_ready) state_nx = do_grant ? EXEC : IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            ptr       <= IDW'(NREQ - 1);
            id        <= '0;
            add_in0   <= '0;
            add_in1   <= '0;
            add_op    <= 1'b0;
            res_valid <= 1'b0;
            res_id    <= '0;
            res_sum   <= '0;
            res_ovf   <= 1'b0;
        end else begin
            state <= state_nx;
            if (do_grant) begin
                add_in0 <= req_a[32*int'(win) +: 32];
                add_in1 <= req_b[32*int'(win) +: 32];
                add_op  <= req_op[win];
                id      <= win;
                ptr     <= win;
            end
            // Adder output has settled on the operands registered last cycle.
            if (state == EXEC) begin
                res_sum   <= add_sum;
                res_ovf   <= add_ovf;
                res_id    <= id;
                res_valid <= 1'b1;
            end else if ((state == HOLD) && res_ready) begin
                res_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_adder_rr_scheduler.sv
// Bench for adder_rr_scheduler: directed cases plus random traffic, checked by a
// queue-based scoreboard against a transaction-level model of the scheduler.
module tb_adder_rr_scheduler;

    localparam int NREQ = 4;

    logic              clock = 1'b0;
    logic              reset_n = 1'b1;
    logic [NREQ-1:0]   req = '0;
    logic [NREQ-1:0]   req_op = '0;
    logic [32*NREQ-1:0] req_a = '0;
    logic [32*NREQ-1:0] req_b = '0;
    logic [NREQ-1:0]   gnt;
    logic [31:0]       add_in0, add_in1, add_sum, res_sum;
    logic              add_op, add_ovf, res_valid, res_ovf;
    logic              res_ready = 1'b0;
    logic [1:0]        res_id;

    adder_rr_scheduler #(.NREQ(NREQ)) dut (
        .clock(clock), .reset_n(reset_n), .req(req), .req_op(req_op),
        .req_a(req_a), .req_b(req_b), .gnt(gnt), .add_in0(add_in0),
        .add_in1(add_in1), .add_op(add_op), .add_sum(add_sum), .add_ovf(add_ovf),
        .res_valid(res_valid), .res_ready(res_ready), .res_id(res_id),
        .res_sum(res_sum), .res_ovf(res_ovf)
    );

    always #5 clock = ~clock;

    // Behavioural shared adder: wide signed arithmetic, overflow = out of int32 range.
    function automatic logic [32:0] adder_model(input logic [31:0] a, input logic [31:0] b,
                                                input logic op);
        longint r;
        logic [63:0] u;
        r = op ? (longint'(signed'(a)) - longint'(signed'(b)))
               : (longint'(signed'(a)) + longint'(signed'(b)));
        u = 64'(r);
        return {(r > 64'sd2147483647) || (r < -64'sd2147483648), u[31:0]};
    endfunction

    assign {add_ovf, add_sum} = adder_model(add_in0, add_in1, add_op);

    // Expected result from sign-bit rules of two's-complement arithmetic.
    function automatic logic [32:0] expect_res(input logic [31:0] a, input logic [31:0] b,
                                               input logic op);
        logic [31:0] s;
        logic v;
        s = op ? a - b : a + b;
        v = op ? ((a[31] != b[31]) && (s[31] != a[31]))
               : ((a[31] == b[31]) && (s[31] != a[31]));
        return {v, s};
    endfunction

    typedef struct {
        logic [1:0]  id;
        logic [31:0] sum;
        logic        ovf;
    } res_t;

    res_t        q[$];
    int          order[$];
    int          vecs = 0;
    int          errs = 0;
    int          mptr = NREQ - 1;
    bit          m_exec = 0;
    bit          m_held = 0;
    logic [NREQ-1:0] last_gnt = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One cycle: sample before the rising edge, compare, advance the model, return at negedge.
    task automatic step();
        logic [NREQ-1:0] eg;
        int w;
        res_t e;
        #4;
        eg = '0;
        w  = -1;
        if (!m_exec && (!m_held || res_ready))
            for (int k = 1; k <= NREQ; k++)
                if (w < 0 && req[(mptr + k) % NREQ]) w = (mptr + k) % NREQ;
        if (w >= 0) eg[w] = 1'b1;
        chk("gnt", 64'(gnt), 64'(eg));
        chk("res_valid", 64'(res_valid), 64'(m_held));
        last_gnt = gnt;
        if (m_held && res_ready) m_held = 0;
        if (m_exec) begin
            m_held = 1;
            m_exec = 0;
        end
        if (w >= 0) begin
            e.id = 2'(w);
            {e.ovf, e.sum} = expect_res(req_a[32*w +: 32], req_b[32*w +: 32], req_op[w]);
            q.push_back(e);
            order.push_back(w);
            mptr   = w;
            m_exec = 1;
        end
        @(negedge clock);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        #1;
        chk("rst_gnt", 64'(gnt), 64'd0);
        chk("rst_in0", 64'(add_in0), 64'd0);
        chk("rst_in1", 64'(add_in1), 64'd0);
        chk("rst_op", 64'(add_op), 64'd0);
        chk("rst_valid", 64'(res_valid), 64'd0);
        chk("rst_id", 64'(res_id), 64'd0);
        chk("rst_sum", 64'(res_sum), 64'd0);
        chk("rst_ovf", 64'(res_ovf), 64'd0);
        q.delete();
        m_exec = 0;
        m_held = 0;
        mptr   = NREQ - 1;
        @(negedge clock);
        req     = '0;
        reset_n = 1'b1;
    endtask

    task automatic set_op(input int i, input logic [31:0] a, input logic [31:0] b,
                          input logic op);
        req_a[32*i +: 32] = a;
        req_b[32*i +: 32] = b;
        req_op[i] = op;
    endtask

    function automatic logic [31:0] rnd_operand();
        case ($urandom_range(0, 5))
            0:       return 32'h8000_0000;
            1:       return 32'h7FFF_FFFF;
            2:       return 32'hFFFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    // Monitor: pops the scoreboard whenever a result is handed over; checks hold stability.
    initial begin
        res_t e;
        logic pv = 1'b0, pr = 1'b0;
        logic [31:0] ps = '0;
        forever begin
            @(negedge clock);
            #4;
            if (reset_n) begin
                if (res_valid && res_ready) begin
                    if (q.size() == 0) begin
                        chk("unexpected_result", 64'(res_id), 64'hDEAD);
                    end else begin
                        e = q.pop_front();
                        chk("res_id", 64'(res_id), 64'(e.id));
                        chk("res_sum", 64'(res_sum), 64'(e.sum));
                        chk("res_ovf", 64'(res_ovf), 64'(e.ovf));
                    end
                end
                if (pv && !pr) begin
                    chk("hold_valid", 64'(res_valid), 64'd1);
                    chk("hold_sum", 64'(res_sum), 64'(ps));
                end
            end
            pv = res_valid && reset_n;
            pr = res_ready;
            ps = res_sum;
        end
    end

    initial begin
        int n;
        #2;
        do_reset();

        // Single add.
        res_ready = 1'b1;
        set_op(0, 32'd5, 32'd7, 1'b0);
        req = 4'b0001;
        step();
        chk("add_gnt", 64'(last_gnt), 64'h1);
        req = '0;
        step();
        chk("add_sum", 64'(res_sum), 64'd12);
        chk("add_ovf", 64'(res_ovf), 64'd0);
        chk("add_id", 64'(res_id), 64'd0);
        step();

        // Subtract with signed overflow.
        set_op(1, 32'h8000_0000, 32'd1, 1'b1);
        req = 4'b0010;
        step();
        req = '0;
        step();
        chk("sub_sum", 64'(res_sum), 64'h7FFF_FFFF);
        chk("sub_ovf", 64'(res_ovf), 64'd1);
        chk("sub_id", 64'(res_id), 64'd1);
        step();

        // Backpressure with requester 3 waiting.
        res_ready = 1'b0;
        set_op(0, 32'd100, 32'd1, 1'b1);
        req = 4'b0001;
        step();
        set_op(3, 32'hFFFF_FFFF, 32'd2, 1'b0);
        req = 4'b1000;
        step();
        for (int i = 0; i < 5; i++) step();
        res_ready = 1'b1;
        step();
        chk("bp_gnt3", 64'(last_gnt), 64'h8);
        req = '0;
        step();
        chk("bp_id", 64'(res_id), 64'd3);
        chk("bp_sum", 64'(res_sum), 64'd1);
        step();

        // Withdrawn request while a result is held.
        res_ready = 1'b0;
        set_op(2, 32'd1, 32'd1, 1'b0);
        req = 4'b0100;
        step();
        req = '0;
        step();
        n = order.size();
        set_op(1, 32'd9, 32'd9, 1'b0);
        req = 4'b0010;
        step();
        req = '0;
        res_ready = 1'b1;
        step();
        step();
        chk("withdrawn_no_gnt", 64'(order.size()), 64'(n));

        // Asynchronous reset while an op is in EXEC.
        set_op(0, 32'd3, 32'd4, 1'b0);
        req = 4'b0001;
        step();
        #2;
        do_reset();
        set_op(2, 32'd10, 32'd20, 1'b0);
        req = 4'b0100;
        step();
        chk("post_rst_gnt", 64'(last_gnt), 64'h4);
        req = '0;
        step();
        step();

        // Round-robin with all requesters held.
        do_reset();
        for (int i = 0; i < NREQ; i++) set_op(i, $urandom, $urandom, 1'($urandom));
        res_ready = 1'b1;
        req = 4'b1111;
        order.delete();
        for (int i = 0; i < 10; i++) step();
        req = '0;
        chk("rr_count", 64'(order.size()), 64'd5);
        if (order.size() >= 5) begin
            chk("rr_0", 64'(order[0]), 64'd0);
            chk("rr_1", 64'(order[1]), 64'd1);
            chk("rr_2", 64'(order[2]), 64'd2);
            chk("rr_3", 64'(order[3]), 64'd3);
            chk("rr_4", 64'(order[4]), 64'd0);
        end
        step();
        step();

        // Random traffic obeying the requester hold rule.
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (last_gnt[i]) begin
                    if ($urandom_range(0, 1) == 0) begin
                        set_op(i, rnd_operand(), rnd_operand(), 1'($urandom));
                    end else begin
                        req[i] = 1'b0;
                    end
                end else if (!req[i]) begin
                    if ($urandom_range(0, 2) == 0) begin
                        set_op(i, rnd_operand(), rnd_operand(), 1'($urandom));
                        req[i] = 1'b1;
                    end
                end else if ($urandom_range(0, 24) == 0) begin
                    req[i] = 1'b0;
                end
            end
            res_ready = ($urandom_range(0, 3) != 0);
            step();
        end

        // Drain.
        req = '0;
        res_ready = 1'b1;
        for (int i = 0; i < 4; i++) step();
        chk("drain_empty", 64'(q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
